// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// The result register only updates on completion, so downstream decoders never see scratch values.
module bin_to_bcd_seq #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * NDIG;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] BIN_MAX = (64'd1 << WIDTH) - 64'd1;

  if (pow10(NDIG) <= BIN_MAX) begin : g_bad_param
    $error("bin_to_bcd_seq: NDIG too small to hold the largest WIDTH-bit value");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shift_q;
  logic [SW-1:0]      scratch_q;
  logic [CW-1:0]      cnt_q;
  logic [SW-1:0]      bcd_q;
  logic               done_q;
  logic               busy_q;

  logic [SW-1:0]      scratch_adj_d;
  logic [SW+WIDTH-1:0] shifted_d;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    scratch_adj_d = scratch_q;
    for (int d = 0; d < NDIG; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5)
        scratch_adj_d[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
  end

  assign shifted_d = {scratch_adj_d[SW-2:0], shift_q, 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch_q, shift_q} <= shifted_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            bcd_q   <= shifted_d[SW+WIDTH-1:WIDTH];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomised checks of bin_to_bcd_seq at WIDTH=8, NDIG=3.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq #(.WIDTH(8), .NDIG(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Every digit must be a legal BCD code at all times.
  always @(negedge clk) begin
    checks++;
    if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9) begin
      errors++;
      $display("FAIL digit_range: bcd=%h has a digit above 9", bcd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
  endtask

  // Accept v, then sample until done; lat is samples after the accept edge (-1 on timeout).
  task automatic run_conv(input logic [7:0] v, output logic [11:0] res,
                          output int lat, output int busy_cnt);
    wait_idle();
    start = 1'b1;
    bin   = v;
    step();
    start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    res = 'x;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i;
        res = bcd;
        break;
      end
      if (busy) busy_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    bin     = 8'd255;
    #2;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
        errors++;
        $display("FAIL reset_state: busy=%b done=%b bcd=%h, need 0 0 000", busy, done, bcd);
      end
    end
    start   = 1'b0;
    reset_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_max();
    logic [11:0] res;
    int lat, bc;
    run_conv(8'd255, res, lat, bc);
    checks++;
    if (res !== 12'h255) begin
      errors++;
      $display("FAIL max_value: bcd=%h, need 255", res);
    end
    checks++;
    if (bc != 8) begin
      errors++;
      $display("FAIL max_busy_cycles: busy for %0d cycles, need 8", bc);
    end
    bin = 8'd3;
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL max_done_pulse: done=%b one cycle later, need 0", done);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bcd !== 12'h255 || busy !== 1'b0) begin
      errors++;
      $display("FAIL max_hold: bcd=%h busy=%b, need 255 0", bcd, busy);
    end
  endtask

  task automatic test_values();
    logic [7:0]  vin [3]  = '{8'd0, 8'd99, 8'd100};
    logic [11:0] vexp [3] = '{12'h000, 12'h099, 12'h100};
    logic [11:0] res;
    int lat, bc;
    for (int k = 0; k < 3; k++) begin
      run_conv(vin[k], res, lat, bc);
      checks++;
      if (res !== vexp[k]) begin
        errors++;
        $display("FAIL value_%0d: bcd=%h, need %h", vin[k], res, vexp[k]);
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL latency_%0d: %0d cycles accept-to-done, need 8", vin[k], lat);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int dones = 0;
    logic [11:0] res = 'x;
    wait_idle();
    start = 1'b1;
    bin   = 8'd37;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        start = 1'b1;
        bin   = 8'd200;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        res = bcd;
      end
      step();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_done_count: %0d done pulses, need 1", dones);
    end
    checks++;
    if (res !== 12'h037 || bcd !== 12'h037) begin
      errors++;
      $display("FAIL ignore_value: bcd=%h, need 037", res);
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1;
    logic [11:0] r1 = 'x, r2 = 'x;
    wait_idle();
    start = 1'b1;
    bin   = 8'd128;
    step();
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = i;
          r1 = bcd;
          bin = 8'd9;
        end else begin
          t2 = i;
          r2 = bcd;
          start = 1'b0;
          break;
        end
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (r1 !== 12'h128 || r2 !== 12'h009) begin
      errors++;
      $display("FAIL b2b_values: got %h then %h, need 128 then 009", r1, r2);
    end
    checks++;
    if (t1 < 0 || t2 < 0 || t2 - t1 != 9) begin
      errors++;
      $display("FAIL b2b_spacing: done at %0d and %0d, need 9 apart", t1, t2);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b after start dropped, need 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [11:0] res;
    int lat, bc;
    wait_idle();
    start = 1'b1;
    bin   = 8'd200;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b bcd=%h, need 0 0 000", busy, done, bcd);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      step();
    end
    checks++;
    if (dones != 0 || bcd !== 12'h000) begin
      errors++;
      $display("FAIL midreset_abort: %0d dones, bcd=%h, need 0 dones and 000", dones, bcd);
    end
    run_conv(8'd42, res, lat, bc);
    checks++;
    if (res !== 12'h042) begin
      errors++;
      $display("FAIL midreset_next: bcd=%h, need 042", res);
    end
  endtask

  task automatic test_random();
    logic [11:0] res;
    logic [7:0]  v;
    int lat, bc;
    for (int n = 0; n < 1000; n++) begin
      v = 8'($urandom_range(0, 255));
      run_conv(v, res, lat, bc);
      checks++;
      if (res !== ref_bcd(int'(v)) || lat != 8) begin
        errors++;
        $display("FAIL random_%0d: bin=%0d bcd=%h lat=%0d, need %h lat=8",
                 n, v, res, lat, ref_bcd(int'(v)));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    test_reset();
    test_max();
    test_values();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
